// File: rtl/multicycle_controller.sv
// Moore control unit for the 16-bit accumulator multi-cycle datapath, plus a retired-instruction counter.
// Strobes are decoded from the current state only, so they drop to 0 as soon as rst rises.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  opcode,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        IRWrite,
    output logic        memToAcc,
    output logic        accWrite,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        PCSrc,
    output logic [1:0]  ALUFunc,
    output logic [15:0] instrCount
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMRD  = 4'd3,
        EXEC   = 4'd4,
        LDWB   = 4'd5,
        STORE  = 4'd6,
        JUMP   = 4'd7,
        BRZ    = 4'd8
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    state_t state;
    state_t state_next;
    logic   retire;

    // Every final state of an instruction always returns to FETCH, so being in it means retiring.
    assign retire = (state == EXEC) || (state == LDWB) || (state == STORE) ||
                    (state == JUMP) || (state == BRZ) ||
                    ((state == DECODE) && (opcode == OP_NOP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            instrCount <= 16'd0;
        end else begin
            state <= state_next;
            if (retire) begin
                instrCount <= instrCount + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:   state_next = FETCH;
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_NOP:  state_next = FETCH;
                    OP_STA:  state_next = STORE;
                    OP_JMP:  state_next = JUMP;
                    OP_JZ:   state_next = BRZ;
                    default: state_next = MEMRD;
                endcase
            end
            MEMRD:  state_next = (opcode == OP_LDA) ? LDWB : EXEC;
            EXEC:   state_next = FETCH;
            LDWB:   state_next = FETCH;
            STORE:  state_next = FETCH;
            JUMP:   state_next = FETCH;
            BRZ:    state_next = FETCH;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        memToAcc    = 1'b0;
        accWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 1'b0;
        PCSrc       = 1'b0;
        ALUFunc     = 2'b00;
        case (state)
            FETCH: begin
                memRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 1'b1;
                PCWrite = 1'b1;
            end
            MEMRD: begin
                IorD    = 1'b1;
                memRead = 1'b1;
            end
            // Only ADD/SUB/AND reach EXEC, so the low opcode bits are the ALU function.
            EXEC: begin
                ALUSrcA  = 1'b1;
                ALUFunc  = opcode[1:0];
                accWrite = 1'b1;
            end
            LDWB: begin
                memToAcc = 1'b1;
                accWrite = 1'b1;
            end
            STORE: begin
                IorD     = 1'b1;
                memWrite = 1'b1;
            end
            JUMP: begin
                PCSrc   = 1'b1;
                PCWrite = 1'b1;
            end
            BRZ: begin
                ALUSrcA     = 1'b1;
                ALUFunc     = 2'b11;
                PCSrc       = 1'b1;
                PCWriteCond = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
